// File: rtl/perc_pkg.sv
// Shared types and constants for the perceptron trainer.
// Holds the FSM encoding, the default threshold and the reset weights.
package perc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_DECIDE,
    S_UPD,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_INC,
    OP_DEC
  } step_op_t;

  localparam int THRESH_DEF = 255;

  // Reset weight for feature i; features past the table start at 0.
  function automatic logic [7:0] rst_w(input int i);
    case (i)
      0:       return 8'd3;
      1:       return 8'd6;
      2:       return 8'd12;
      3:       return 8'd24;
      4:       return 8'd48;
      5:       return 8'd96;
      6:       return 8'd192;
      7:       return 8'd192;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/perc_train_if.sv
// Sample/result handshake and weight read port of the trainer.
// The slave side is the trainer, the master side its user.
interface perc_train_if #(
  parameter int WIDTH = 8,
  parameter int WBITS = 8
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             label;
  logic             out_valid;
  logic             out_ready;
  logic             pred;
  logic             err;
  logic [IW-1:0]    w_rd_idx;
  logic [WBITS-1:0] w_rd_data;

  modport master (
    output in_valid, data_in, label,
    output out_ready, w_rd_idx,
    input  in_ready, out_valid,
    input  pred, err, w_rd_data
  );

  modport slave (
    input  in_valid, data_in, label,
    input  out_ready, w_rd_idx,
    output in_ready, out_valid,
    output pred, err, w_rd_data
  );

endinterface

// File: rtl/perc_sat_step.sv
// Saturating +1 / -1 step applied to one weight.
// Increment sticks at all-ones, decrement sticks at zero.
module perc_sat_step
  import perc_pkg::*;
#(
  parameter int WBITS = 8
) (
  input  logic [WBITS-1:0] w_i,
  input  step_op_t         op_i,
  output logic [WBITS-1:0] w_o
);

  // Next weight value, clamped at both ends of the range.
  always_comb begin
    w_o = w_i;
    unique case (1'b1)
      (op_i == OP_INC): if (w_i != '1) w_o = w_i + 1'b1;
      (op_i == OP_DEC): if (w_i != '0) w_o = w_i - 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/perc_train.sv
// Serial perceptron: accumulate one weight per cycle, decide,
// then on a wrong guess nudge the weights of active features.
module perc_train
  import perc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int WBITS  = 8,
  parameter int SBITS  = 12,
  parameter int THRESH = THRESH_DEF
) (
  input logic         clk,
  input logic         rst,
  perc_train_if.slave bus
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    LAST = IW'(WIDTH - 1);
  localparam logic [SBITS-1:0] TH   = SBITS'(THRESH);

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic             label_q;
  logic [SBITS-1:0] sum_q;
  logic [IW-1:0]    idx_q;
  logic             pred_q;
  logic             err_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WBITS-1:0] w_q [WIDTH];

  logic             bit_cur;
  logic [WBITS-1:0] w_cur;
  logic [WBITS-1:0] w_d;
  logic             pred_d;
  step_op_t         op;

  assign bit_cur = data_q[idx_q];
  assign w_cur   = w_q[idx_q];
  assign pred_d  = (sum_q >= TH);

  // Direction of the weight nudge for the current feature.
  always_comb begin
    op = OP_HOLD;
    if (state_q == S_UPD && bit_cur)
      op = label_q ? OP_INC : OP_DEC;
  end

  perc_sat_step #(
    .WBITS(WBITS)
  ) u_step (
    .w_i (w_cur),
    .op_i(op),
    .w_o (w_d)
  );

  // Control FSM with accumulator and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      label_q     <= 1'b0;
      sum_q       <= '0;
      idx_q       <= '0;
      pred_q      <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            data_q     <= bus.data_in;
            label_q    <= bus.label;
            sum_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_ACC;
          end
        end
        S_ACC: begin
          if (bit_cur)
            sum_q <= sum_q + SBITS'(w_cur);
          if (idx_q == LAST) begin
            idx_q   <= '0;
            state_q <= S_DECIDE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DECIDE: begin
          pred_q <= pred_d;
          err_q  <= (pred_d != label_q);
          if (pred_d != label_q) begin
            state_q <= S_UPD;
          end else begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_UPD: begin
          if (idx_q == LAST) begin
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Weight file: reload on reset, one write per UPD cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++)
        w_q[i] <= WBITS'(rst_w(i));
    end else if (state_q == S_UPD) begin
      w_q[idx_q] <= w_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pred      = pred_q;
  assign bus.err       = err_q;
  assign bus.w_rd_data = w_q[bus.w_rd_idx];

endmodule

// File: tb/tb_perc_train.sv
// Scoreboard bench for perc_train with directed samples.
// Expected pred/err/latency are queued by stimulus, checked by a monitor.
module tb_perc_train;
  import perc_pkg::*;

  typedef struct {
    logic p;
    logic e;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc     = 0;
  int   acc_cyc = 0;
  bit   shown   = 1'b0;

  int tbl[8] = '{3, 6, 12, 24, 48, 96, 192, 192};

  logic [7:0] sw;
  step_op_t   sop;
  logic [7:0] sw_o;

  perc_train_if #(.WIDTH(8), .WBITS(8)) bus ();

  perc_train dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  perc_sat_step #(.WBITS(8)) u_sat (
    .w_i (sw),
    .op_i(sop),
    .w_o (sw_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp_v);
    end
  endtask

  // Track accept edges and clear the per-result flag on handshake.
  always @(posedge clk) begin
    if (rst) begin
      shown = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) acc_cyc = cyc;
      if (bus.out_valid && bus.out_ready) shown = 1'b0;
    end
    cyc++;
  end

  // Monitor: compare the first cycle of each result with the queue head.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && !shown) begin
      shown = 1'b1;
      if (sbq.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_pred", bus.pred, mon_e.p);
        chk("sb_err", bus.err, mon_e.e);
        chk("sb_latency", cyc - acc_cyc, mon_e.lat);
      end
    end
  end

  task automatic chk_w(input int idx, input int exp_v);
    bus.w_rd_idx = 3'(idx);
    #1;
    chk($sformatf("w%0d", idx), bus.w_rd_data, exp_v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // hold<0: out_ready already high; otherwise stall hold cycles.
  task automatic send(input logic [7:0] d, input logic l,
                      input logic p, input logic e,
                      input int hold, input bit spam);
    exp_t x;
    int   n;
    x.p   = p;
    x.e   = e;
    x.lat = e ? 18 : 10;
    sbq.push_back(x);
    @(negedge clk);
    bus.data_in  = d;
    bus.label    = l;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) chk("timeout_out_valid", 0, 1);
    if (hold < 0) begin
      @(negedge clk);
      chk("release_first", bus.out_valid, 0);
      bus.out_ready = 1'b0;
    end else begin
      for (int i = 0; i < hold; i++) begin
        if (spam) begin
          bus.in_valid = 1'b1;
          bus.data_in  = 8'hFF;
          bus.label    = 1'b1;
        end
        @(negedge clk);
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_pred", bus.pred, p);
        chk("hold_err", bus.err, e);
        chk("hold_in_ready", bus.in_ready, 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("post_valid", bus.out_valid, 0);
    end
    chk("post_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.label     = 1'b0;
    bus.out_ready = 1'b0;
    bus.w_rd_idx  = '0;
    sw  = '0;
    sop = OP_HOLD;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_pred", bus.pred, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) chk_w(i, tbl[i]);

    // 48+96+192+192 = 528, correct guess
    send(8'hF0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    chk_w(4, 48);
    chk_w(5, 96);
    chk_w(7, 192);

    // 3+6+24 = 33, missed positive
    send(8'h0B, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    chk_w(0, 4);
    chk_w(1, 7);
    chk_w(2, 12);
    chk_w(3, 25);

    // 192+192 = 384, false positive
    send(8'hC0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    chk_w(6, 191);
    chk_w(7, 191);
    chk_w(0, 4);
    chk_w(5, 96);

    // 4+7+12+25 = 48, stall 5 cycles with a stray sample offered
    send(8'h0F, 1'b0, 1'b0, 1'b0, 5, 1'b1);

    // 48+96 = 144, out_ready already high
    bus.out_ready = 1'b1;
    send(8'h30, 1'b0, 1'b0, 1'b0, -1, 1'b0);

    do_reset();
    for (int i = 0; i < 8; i++) chk_w(i, tbl[i]);

    // 3+12+48+192 = 255 exactly: active
    send(8'h55, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    chk_w(0, 2);
    chk_w(2, 11);
    chk_w(4, 47);
    chk_w(6, 191);
    chk_w(1, 6);
    // 2+11+47+191 = 251: inactive, then trained back up
    send(8'h55, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send(8'h55, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    chk_w(0, 3);
    chk_w(6, 192);
    send(8'h55, 1'b1, 1'b1, 1'b0, 0, 1'b0);

    // Abort in the 4th UPD cycle (cycle 13 after accept)
    do_reset();
    @(negedge clk);
    bus.data_in  = 8'h0B;
    bus.label    = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_pred", bus.pred, 0);
    chk("abort_err", bus.err, 0);
    for (int i = 0; i < 8; i++) chk_w(i, tbl[i]);
    repeat (25) @(negedge clk);
    chk("abort_no_result", bus.out_valid, 0);

    // Drive w0 down to 0 and past it: 387, 384, 381, 378
    send(8'hC1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    send(8'hC1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    send(8'hC1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    chk_w(0, 0);
    send(8'hC1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    chk_w(0, 0);
    chk_w(6, 188);
    chk_w(7, 188);

    // Saturating step unit at both rails
    sw = 8'd255; sop = OP_INC; #1;
    chk("sat_inc_255", sw_o, 255);
    sw = 8'd254; sop = OP_INC; #1;
    chk("sat_inc_254", sw_o, 255);
    sw = 8'd0; sop = OP_DEC; #1;
    chk("sat_dec_0", sw_o, 0);
    sw = 8'd1; sop = OP_DEC; #1;
    chk("sat_dec_1", sw_o, 0);
    sw = 8'd7; sop = OP_HOLD; #1;
    chk("sat_hold", sw_o, 7);

    repeat (2) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perc_train.md
PERC_TRAIN -- requirements
Module: perc_train

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of input features and weights.
REQ-002 The block SHALL have parameter WBITS, default 8, meaning the unsigned weight width.
REQ-003 The block SHALL have parameter SBITS, default 12, meaning the accumulator width.
REQ-004 The block SHALL have parameter THRESH, default 255, meaning the activation threshold (active when sum >= THRESH).
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  sample offered.
REQ-008 in_ready  output  1  block can accept a sample.
REQ-009 data_in  input  WIDTH  binary feature vector, bit i pairs with weight i.
REQ-010 label  input  1  target class for the sample.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 pred  output  1  predicted class, computed with pre-update weights.
REQ-014 err  output  1  pred != label; a weight update was applied.
REQ-015 w_rd_idx  input  clog2(WIDTH)  weight read address.
REQ-016 w_rd_data  output  WBITS  combinational read of weight[w_rd_idx].

Function
REQ-017 FSM states SHALL be IDLE, ACC, DECIDE, UPD, DONE.
REQ-018 IDLE: in_ready=1; on in_valid&&in_ready, latch data_in and label, clear sum to 0, clear index, go to ACC.
REQ-019 ACC: one weight per cycle, sum += data_bit[idx] ? weight[idx] : 0; after idx = WIDTH-1, go to DECIDE (WIDTH cycles total).
REQ-020 DECIDE: pred = (sum >= THRESH); err = (pred != label); go to UPD if err, else go to DONE.
REQ-021 UPD: one weight per cycle for WIDTH cycles; only weights whose latched bit is 1 are changed.
REQ-022 In UPD, label=1/pred=0 SHALL increment the weight, saturating at 2^WBITS-1.
REQ-023 In UPD, label=0/pred=1 SHALL decrement the weight, saturating at 0.
REQ-024 DONE: out_valid=1 with pred and err held stable until out_ready; on out_valid&&out_ready go to IDLE.
REQ-025 in_ready SHALL be 0 in every state except IDLE; the block accepts no new sample until the result is taken.
REQ-026 Latency from accept edge to first out_valid cycle SHALL be WIDTH+2 cycles without error, and 2*WIDTH+2 cycles with error.
REQ-027 Sum SHALL be unsigned SBITS wide with no overflow for defaults; the maximum is 8*255 = 2040.
REQ-028 Equality sum == THRESH SHALL count as active.
REQ-029 out_ready held high SHALL release DONE in its first cycle.
REQ-030 out_ready asserted outside DONE SHALL have no effect.
REQ-031 w_rd_data SHALL reflect an update on the cycle after the write edge.

Reset
REQ-032 rst SHALL force IDLE, sum=0, index=0, in_ready=1, out_valid=0, pred=0, and err=0.
REQ-033 rst SHALL reload the weights to 3, 6, 12, 24, 48, 96, 192, 192 (index 0..7).
REQ-034 rst asserted mid-ACC or mid-UPD SHALL abort the sample with no result and no partial weight change retained beyond the reload.

Structure
REQ-035 The shared package perc_pkg SHALL hold the FSM state encoding, default THRESH, and the reset weight table.
REQ-036 The sub-module perc_sat_step SHALL perform the combinational saturating +1/-1 weight update; the FSM, accumulator, and weight register file stay in perc_train.

Verification
REQ-037 Scenario: data_in=0xF0, label=1 -> sum=528, pred=1, err=0, out_valid 10 cycles after accept, weights unchanged.
REQ-038 Scenario: data_in=0x0B, label=1 -> sum=33, pred=0, err=1, out_valid after 18 cycles, then w0=4, w1=7, w3=25.
REQ-039 Scenario: data_in=0xC0, label=0 -> sum=384, pred=1, err=1, then w6=191, w7=191, others unchanged.
REQ-040 Scenario: out_ready held low 5 cycles in DONE -> out_valid, pred, and err stable, in_ready=0, and a second in_valid is ignored until the handshake.
REQ-041 Scenario: rst pulsed in the 4th cycle of UPD -> FSM is IDLE, out_valid=0, and all weights read back as the reset table.
REQ-042 Scenario: weight at 255 with an increment request -> weight stays 255; weight at 0 with a decrement request -> weight stays 0.
